bwt_output_gen: RTL
===================

// Module: bwt_output_gen
// PURPOSE
//  Final BWT stage, directly downstream of the prefix-doubling suffix sorter.
//  - Consumes the sorted suffix array and the original string.
//  - Streams the BWT column L[i] = S[(SA[i]-1) mod N], one byte per beat, over a valid/ready port.
//  - Reports the primary index, i.e. the i where SA[i]==0.
// PARAMETERS
//  STRING_LEN  8  string/suffix-array length N, 2..255; index width is 8 bits
// PORTS
//  clk            in   1            single clock, rising edge
//  rst            in   1            asynchronous, active-low reset
//  start          in   1            pulse; sampled only in IDLE
//  input_string   in   8 x N        S[0..N-1], unpacked [7:0] [STRING_LEN-1:0]
//  suffixes_in    in   8 x N        SA[0..N-1], same layout as the sorter's suffixes_out
//  busy           out  1            high in LOAD/STREAM/DONE
//  bwt_valid      out  1            output beat valid
//  bwt_ready      in   1            downstream accept
//  bwt_data       out  8            L[i]
//  bwt_idx        out  8            i of current beat
//  bwt_last       out  1            high with the beat where i==N-1
//  primary_idx    out  8            row where SA[i]==0
//  primary_valid  out  1            primary_idx valid
//  done           out  1            1-cycle pulse at end of run
//  err            out  1            sticky bad-suffix-array flag
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; every output is 0.
//  FSM states: IDLE -> LOAD -> STREAM -> DONE -> IDLE.
//  - IDLE: on start, capture input_string and suffixes_in into internal regs.
//    Also clear err, primary_valid and primary_idx; i=0; go to LOAD.
//    Inputs are ignored after capture.
//  - LOAD: one cycle; compute beat 0 into the output regs; bwt_valid=1 on entry to STREAM.
//  - STREAM: a beat transfers when bwt_valid && bwt_ready.
//    bwt_data/bwt_idx/bwt_last stay stable while valid && !ready.
//    On transfer with i<N-1: present beat i+1 next cycle; no bubbles.
//    On transfer with i==N-1: bwt_valid=0, go to DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy drops with the IDLE entry.
//  Latency: start at cycle 0 -> beat 0 valid at cycle 2.
//    With ready held high: last beat at cycle N+1, done at cycle N+2.
//  Wrap rule: SA[i]==0 selects S[N-1]; otherwise S[SA[i]-1].
//  Primary index: when the beat with SA[i]==0 is generated, latch primary_idx=i.
//    primary_valid goes high with done; held until the next accepted start.
//    If no entry is 0: primary_idx=0, primary_valid=0, err=1.
//  Range: SA[i]>=N -> bwt_data=8'h00 for that beat; err=1 (sticky until next start).
//    The stream still completes all N beats.
//  start while busy: ignored; no restart and no effect on the stream.
//  Reset mid-run: immediate abort to IDLE; all outputs 0; no done pulse.
// CONFIGURATION
//  BWT_DUP_CHECK_EN
//   - Defined: an N-bit seen-bitmap is cleared at start and set per generated beat.
//     An SA value already marked sets err (sticky); the stream still completes.
//   - Undefined: no bitmap; duplicates go undetected.
//     err reflects only the range and missing-zero checks.
// TESTING
//  1 S="AAAAAAA$", SA=[7,6,5,4,3,2,1,0], ready=1
//    -> bwt "AAAAAAA$" at cycles 2..9; last at idx 7; done at cycle 10; primary_idx=7.
//  2 S="01234567", SA=[0..7], ready toggled 1,0,0,1...
//    -> bwt "70123456"; data/idx held while ready=0; primary_idx=0; err=0.
//  3 SA=[0,1,2,9,4,5,6,7] -> beat 3 data=8'h00; err=1; all 8 beats delivered; done pulses.
//  4 SA=[0,1,1,3,4,5,6,7]
//    -> with BWT_DUP_CHECK_EN: err=1 after beat 2.
//    -> without: err=0.
//    Both: primary_idx=0.
//  5 start re-pulsed at beat 3 -> ignored.
//    rst low at beat 5 -> all outputs 0 next edge, no done; a fresh start then runs normally.
//  6 SA=[1..7,1] (no zero) -> err=1, primary_valid=0 at done.

Source files
------------

// File: rtl/bwt_output_gen_if.sv
// BWT output stream interface: one L-column byte per beat, valid/ready handshake.
// The master (bwt_output_gen) drives data/idx/last/valid; the slave drives ready.
interface bwt_output_gen_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic [7:0] idx;
  logic       last;

  modport master (output valid, data, idx, last, input ready);
  modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/bwt_output_gen.sv
// bwt_output_gen: final BWT stage. Streams L[i] = S[(SA[i]-1) mod N] and
// reports the primary index (row where SA[i]==0).
// Optional feature macro: BWT_DUP_CHECK_EN (duplicate suffix-array entry detection).
//
//   state  | meaning
//   IDLE   | waiting for start; inputs captured on start
//   LOAD   | one cycle, beat 0 computed into the output registers
//   STREAM | beats presented on valid/ready, next beat loaded on each transfer
//   DONE   | one-cycle done pulse, then back to IDLE
module bwt_output_gen #(
  parameter int STRING_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [7:0]          input_string_i [STRING_LEN-1:0],
  input  logic [7:0]          suffixes_in_i  [STRING_LEN-1:0],
  bwt_output_gen_if.master    bwt,
  output logic                busy_o,
  output logic [7:0]          primary_idx_o,
  output logic                primary_valid_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int         IW       = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam logic [7:0] N8       = 8'(STRING_LEN);
  localparam logic [7:0] LAST_IDX = 8'(STRING_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM, ST_DONE} state_t;

  state_t     state_q;
  logic [7:0] s_q  [STRING_LEN-1:0];
  logic [7:0] sa_q [STRING_LEN-1:0];
  logic       valid_q, last_q, busy_q, done_q, err_q, pvalid_q, zero_seen_q;
  logic [7:0] data_q, idx_q, pidx_q;
`ifdef BWT_DUP_CHECK_EN
  logic [STRING_LEN-1:0] seen_q;
  logic                  beat_dup_d;
`endif

  logic [7:0]    gen_idx_d;
  logic [7:0]    sa_d;
  logic [IW-1:0] sa_m1_d;
  logic [7:0]    beat_data_d;
  logic          beat_range_err_d;
  logic          beat_zero_d;
  logic          xfer_d;
  logic          gen_fire_d;

  // Next-beat generation: index, wrapped source byte and per-beat error flags.
  always_comb begin
    xfer_d           = (state_q == ST_STREAM) && valid_q && bwt.ready;
    gen_fire_d       = (state_q == ST_LOAD) || (xfer_d && (idx_q != LAST_IDX));
    gen_idx_d        = (state_q == ST_LOAD) ? 8'd0 : idx_q + 8'd1;
    sa_d             = sa_q[gen_idx_d[IW-1:0]];
    sa_m1_d          = sa_d[IW-1:0] - IW'(1);
    beat_range_err_d = (sa_d >= N8);
    beat_zero_d      = (sa_d == 8'd0);
    beat_data_d      = 8'h00;
    if (!beat_range_err_d) begin
      if (beat_zero_d) beat_data_d = s_q[STRING_LEN-1];
      else             beat_data_d = s_q[sa_m1_d];
    end
`ifdef BWT_DUP_CHECK_EN
    beat_dup_d = !beat_range_err_d && seen_q[sa_d[IW-1:0]];
`endif
  end

  // Sequencer FSM with registered outputs; beat loading shared by LOAD and STREAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      for (int k = 0; k < STRING_LEN; k++) begin
        s_q[k]  <= 8'h00;
        sa_q[k] <= 8'h00;
      end
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pvalid_q    <= 1'b0;
      zero_seen_q <= 1'b0;
      data_q      <= 8'h00;
      idx_q       <= 8'h00;
      pidx_q      <= 8'h00;
`ifdef BWT_DUP_CHECK_EN
      seen_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            s_q         <= input_string_i;
            sa_q        <= suffixes_in_i;
            err_q       <= 1'b0;
            pvalid_q    <= 1'b0;
            pidx_q      <= 8'h00;
            zero_seen_q <= 1'b0;
            idx_q       <= 8'h00;
            busy_q      <= 1'b1;
`ifdef BWT_DUP_CHECK_EN
            seen_q      <= '0;
`endif
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          valid_q <= 1'b1;
          state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (xfer_d && (idx_q == LAST_IDX)) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            if (zero_seen_q) pvalid_q <= 1'b1;
            else             err_q    <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase

      if (gen_fire_d) begin
        data_q <= beat_data_d;
        idx_q  <= gen_idx_d;
        last_q <= (gen_idx_d == LAST_IDX);
        if (beat_range_err_d) err_q <= 1'b1;
        if (!beat_range_err_d && beat_zero_d) begin
          zero_seen_q <= 1'b1;
          pidx_q      <= gen_idx_d;
        end
`ifdef BWT_DUP_CHECK_EN
        if (beat_dup_d) err_q <= 1'b1;
        if (!beat_range_err_d) seen_q[sa_d[IW-1:0]] <= 1'b1;
`endif
      end
    end
  end

  assign bwt.valid       = valid_q;
  assign bwt.data        = data_q;
  assign bwt.idx         = idx_q;
  assign bwt.last        = last_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign primary_idx_o   = pidx_q;
  assign primary_valid_o = pvalid_q;

endmodule
